// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port main-memory bus between instruction fetch (IF) and
// load/store (MEM). Data requests normally win. A starvation counter forces a
// fetch grant after STARVE_MAX back-to-back data grants made while a fetch
// was waiting. Each granted access is registered onto a variable-latency
// request/ack bus. An optional timeout aborts an access that is never acked.
// The block also produces the pipeline stall.
//
// Handshake: a requester raises *_req with its address/data stable and holds
// it until the one-cycle *_done pulse. Requests are sampled only while the
// arbiter is idle. bus_req stays high until the cycle in which bus_ack is
// seen or the timeout expires. bus_ack is ignored whenever bus_req is low.
//
// Ports
//   cpu_clk, cpu_rstn        clock; asynchronous active-low reset
//   if_req/if_addr           fetch request and word address
//   if_done/if_rdata         fetch completion pulse and registered instruction
//   mem_req/mem_we/mem_addr/mem_wdata
//                            data request; mem_we == 0 means a load
//   mem_done/mem_rdata       data completion pulse and registered load data
//   bus_req/bus_we/bus_addr/bus_wdata
//                            registered memory bus request
//   bus_ack/bus_rdata        memory completion; read data valid with the ack
//   bus_timeout              pulses together with the done of an aborted access
//   pipe_stall               a request is outstanding and not finishing this cycle
//   dbg_state_o              current FSM state (0 idle, 1 bus, 2 resp)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic [3:0]  mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        bus_req,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout,
    output logic        pipe_stall,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // wait_cnt only has to reach TIMEOUT-1.
    localparam int unsigned WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

    state_e              state_q,     state_d;
    logic                owner_q,     owner_d;      // 1 = data access, 0 = fetch
    logic                timeout_q,   timeout_d;
    logic [WAIT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic [STARVE_W-1:0] starve_q,    starve_d;
    logic [3:0]          bus_we_q,    bus_we_d;
    logic [31:0]         bus_addr_q,  bus_addr_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;
    logic [31:0]         if_rdata_q,  if_rdata_d;
    logic [31:0]         mem_rdata_q, mem_rdata_d;

    logic        starve_full;
    logic        grant_mem;
    logic        grant_if;
    logic        timeout_hit;
    logic [31:0] capture_val;

    assign starve_full = (starve_q == STARVE_TOP);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);

    // State register
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= '0;
            starve_q    <= '0;
            bus_we_q    <= 4'b0000;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
            starve_q    <= starve_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        timeout_d   = timeout_q;
        wait_cnt_d  = wait_cnt_q;
        starve_d    = starve_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        grant_mem   = 1'b0;
        grant_if    = 1'b0;
        // An aborted access returns zero instead of bus data.
        capture_val = bus_ack ? bus_rdata : 32'h0;

        unique case (state_q)
            ST_IDLE: begin
                timeout_d  = 1'b0;
                wait_cnt_d = '0;
                grant_mem  = mem_req & ~(if_req & starve_full);
                grant_if   = if_req & ~grant_mem;
                if (grant_mem) begin
                    owner_d     = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    state_d     = ST_BUS;
                    // Count only data grants that made a waiting fetch wait longer.
                    if (!if_req) begin
                        starve_d = '0;
                    end else if (!starve_full) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (grant_if) begin
                    owner_d     = 1'b0;
                    bus_we_d    = 4'b0000;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = 32'h0;
                    starve_d    = '0;
                    state_d     = ST_BUS;
                end
            end
            ST_BUS: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                // An ack in the last allowed cycle still counts as a normal completion.
                if (bus_ack || timeout_hit) begin
                    timeout_d = ~bus_ack;
                    state_d   = ST_RESP;
                    // Stores leave the load data register untouched.
                    if (bus_we_q == 4'b0000) begin
                        if (owner_q) begin
                            mem_rdata_d = capture_val;
                        end else begin
                            if_rdata_d = capture_val;
                        end
                    end
                end
            end
            ST_RESP: begin
                wait_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus_req     = (state_q == ST_BUS);
        if_done     = (state_q == ST_RESP) & ~owner_q;
        mem_done    = (state_q == ST_RESP) & owner_q;
        bus_timeout = (state_q == ST_RESP) & timeout_q;
        pipe_stall  = (if_req & ~if_done) | (mem_req & ~mem_done);
        bus_we      = bus_we_q;
        bus_addr    = bus_addr_q;
        bus_wdata   = bus_wdata_q;
        if_rdata    = if_rdata_q;
        mem_rdata   = mem_rdata_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Randomised bench for mem_port_arbiter (TIMEOUT=8, STARVE_MAX=4).
// One process drives two requesters and a memory responder. It also runs a
// transaction-level model. When the model predicts a grant, it picks the
// latency and read data, then pushes the expected bus transaction and the
// expected completion (cycle, owner, timeout, rdata) into queues.
// A monitor on the falling edge pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int TIMEOUT    = 8;
  localparam int STARVE_MAX = 4;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_timeout;
  logic        pipe_stall;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(
    .TIMEOUT    (TIMEOUT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rstn    (cpu_rstn),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_done     (if_done),
    .if_rdata    (if_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_done    (mem_done),
    .mem_rdata   (mem_rdata),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .bus_timeout (bus_timeout),
    .pipe_stall  (pipe_stall),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    int          cyc;
    bit          fetch;
    bit          to;
    logic [31:0] if_rd;
    logic [31:0] mem_rd;
  } done_t;

  bus_t  exp_bus_q[$];
  done_t exp_done_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  bit          if_act, mem_act;
  int          if_dcyc, mem_dcyc;          // predicted done cycle of a granted request
  logic [31:0] if_a, m_a, m_wd;
  logic [3:0]  m_we;
  int          free_c, bus_start, resp_c, ack_c;
  logic [31:0] ack_d;
  int          starve;
  logic [31:0] if_model, mem_model;        // values the rdata registers should hold

  task automatic model_reset();
    if_act    = 1'b0;
    mem_act   = 1'b0;
    if_dcyc   = -1;
    mem_dcyc  = -1;
    free_c    = 0;
    bus_start = -1;
    resp_c    = -1;
    ack_c     = -1;
    starve    = 0;
    if_model  = 32'h0;
    mem_model = 32'h0;
    exp_bus_q.delete();
    exp_done_q.delete();
    if_req    = 1'b0;
    if_addr   = 32'h0;
    mem_req   = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
  endtask

  // One clock cycle of requesters, responder and arbitration model.
  task automatic step(input int p_if, input int p_mem, input int lat_lo, input int lat_hi,
                      input bit allow_new);
    int n, lat, eff;
    bit to, if_pend, mem_pend, give_mem, in_bus;
    logic [31:0] r;
    bus_t  b;
    done_t d;
    @(posedge cpu_clk);
    #1;
    n = cyc;
    // Requesters release the cycle after their done pulse and may reissue at once.
    if (if_act && if_dcyc == n - 1) begin
      if_act  = 1'b0;
      if_dcyc = -1;
    end
    if (mem_act && mem_dcyc == n - 1) begin
      mem_act  = 1'b0;
      mem_dcyc = -1;
    end
    if (!if_act && allow_new && $urandom_range(0, 99) < p_if) begin
      if_act = 1'b1;
      r      = $urandom();
      if_a   = {r[31:2], 2'b00};
    end
    if (!mem_act && allow_new && $urandom_range(0, 99) < p_mem) begin
      mem_act = 1'b1;
      r       = $urandom();
      m_a     = r;
      m_we    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      m_wd    = $urandom();
    end
    if_req    = if_act;
    if_addr   = if_a;
    mem_req   = mem_act;
    mem_addr  = m_a;
    mem_we    = m_we;
    mem_wdata = m_wd;
    // Memory responder: real ack inside the bus window, spurious acks elsewhere.
    in_bus = (n >= bus_start) && (n < resp_c);
    if (n == ack_c) begin
      bus_ack   = 1'b1;
      bus_rdata = ack_d;
    end else begin
      bus_ack   = !in_bus && ($urandom_range(0, 4) == 0);
      bus_rdata = $urandom();
    end
    // Arbitration: only while no access is in flight.
    if_pend  = if_act && (if_dcyc < 0);
    mem_pend = mem_act && (mem_dcyc < 0);
    if (n >= free_c && (if_pend || mem_pend)) begin
      give_mem  = mem_pend && !(if_pend && starve == STARVE_MAX);
      lat       = $urandom_range(lat_lo, lat_hi);
      to        = (lat > TIMEOUT - 1);
      eff       = to ? TIMEOUT - 1 : lat;
      bus_start = n + 1;
      resp_c    = n + 2 + eff;
      free_c    = resp_c + 1;
      ack_c     = to ? -1 : n + 1 + lat;
      ack_d     = $urandom();
      b.cyc     = n + 1;
      if (give_mem) begin
        starve   = if_pend ? ((starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1) : 0;
        if (m_we == 4'b0000) mem_model = to ? 32'h0 : ack_d;
        b.addr   = m_a;
        b.we     = m_we;
        b.wdata  = m_wd;
        mem_dcyc = resp_c;
      end else begin
        starve   = 0;
        if_model = to ? 32'h0 : ack_d;
        b.addr   = if_a;
        b.we     = 4'b0000;
        b.wdata  = 32'h0;
        if_dcyc  = resp_c;
      end
      d.cyc    = resp_c;
      d.fetch  = !give_mem;
      d.to     = to;
      d.if_rd  = if_model;
      d.mem_rd = mem_model;
      exp_bus_q.push_back(b);
      exp_done_q.push_back(d);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((if_act || mem_act || cyc < free_c) && budget < 100) begin
      step(0, 0, 0, 0, 1'b0);
      budget++;
    end
    step(0, 0, 0, 0, 1'b0);
    chk("drain_pending", {if_act, mem_act}, 2'b00);
    chk("drain_queues", {exp_bus_q.size(), exp_done_q.size()}, 64'h0);
  endtask

  // ---------------- monitor ----------------
  int    m_n;
  bit    m_dexp;
  done_t m_d;
  bus_t  m_b;

  always @(negedge cpu_clk) begin
    if (mon_en) begin
      m_n    = cyc;
      m_dexp = (exp_done_q.size() > 0) && (exp_done_q[0].cyc == m_n);
      if (m_dexp) m_d = exp_done_q[0];
      chk("bus_req", bus_req, (m_n >= bus_start) && (m_n < resp_c));
      if (exp_bus_q.size() > 0 && exp_bus_q[0].cyc == m_n) begin
        m_b = exp_bus_q.pop_front();
        chk("bus_fields", {bus_addr, bus_we, bus_wdata}, {m_b.addr, m_b.we, m_b.wdata});
      end
      chk("done_flags", {if_done, mem_done, bus_timeout},
          m_dexp ? {m_d.fetch, ~m_d.fetch, m_d.to} : 3'b000);
      chk("pipe_stall", pipe_stall,
          (if_req & ~(m_dexp & m_d.fetch)) | (mem_req & ~(m_dexp & ~m_d.fetch)));
      if (m_dexp) begin
        chk("rdata", {if_rdata, mem_rdata}, {m_d.if_rd, m_d.mem_rd});
        void'(exp_done_q.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    cpu_rstn = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1;
    chk("reset_bus", {bus_req, bus_we, bus_addr, bus_wdata}, 69'h0);
    chk("reset_done", {if_done, mem_done, bus_timeout, pipe_stall}, 4'h0);
    chk("reset_rdata", {if_rdata, mem_rdata}, 64'h0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    free_c   = cyc;
    mon_en   = 1'b1;

    // Both requesters always busy: exercises the starvation override.
    repeat (300) step(100, 100, 0, 2, 1'b1);
    // General mix with short latencies.
    repeat (1000) step(40, 50, 0, 5, 1'b1);
    // Latencies around the timeout boundary.
    repeat (400) step(50, 50, TIMEOUT - 2, TIMEOUT + 2, 1'b1);
    drain();

    // Reset in the middle of a bus access.
    step(100, 0, 20, 20, 1'b1);
    step(0, 0, 0, 0, 1'b0);
    @(negedge cpu_clk);
    #2;
    chk("bus_before_reset", bus_req, 1'b1);
    mon_en   = 1'b0;
    cpu_rstn = 1'b0;
    #1;
    chk("reset_drops_bus_req", {bus_req, if_done, mem_done}, 3'b000);
    model_reset();
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    free_c   = cyc;
    mon_en   = 1'b1;
    #1;
    chk("post_reset_rdata", {if_rdata, mem_rdata}, 64'h0);
    chk("post_reset_bus", {bus_req, bus_we, bus_addr, bus_wdata}, 69'h0);
    repeat (6) step(0, 0, 0, 0, 1'b0);

    // Normal operation after reset.
    repeat (300) step(50, 50, 0, TIMEOUT + 1, 1'b1);
    drain();

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
